fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 76 +++++++
 rtl/fetch.sv | 150 +++++++++++++++
 tb/tb_fetch.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch unit.
//   FETCH_STATE_WIDTH  width of the fetch FSM state register
//   ST_BOOT/ST_RUN     FSM encodings; ST_ERR exists only with FETCH_MISALIGN_CHK_EN
//   pc_align()         clears the byte-offset bits of a PC
package fetch_pkg;

    localparam int FETCH_STATE_WIDTH = 2;

    localparam logic [FETCH_STATE_WIDTH-1:0] ST_BOOT = 2'd0;
    localparam logic [FETCH_STATE_WIDTH-1:0] ST_RUN  = 2'd1;
`ifdef FETCH_MISALIGN_CHK_EN
    localparam logic [FETCH_STATE_WIDTH-1:0] ST_ERR  = 2'd2;
`endif

    function automatic logic [31:0] pc_align(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: instruction buffer holding {instruction, PC} pairs.
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_push, i_push_data/pc    write an entry (accepted when not full, or when popping)
//   i_pop                     remove the head entry
//   i_flush                   empty the buffer; wins over push and pop
//   o_head_data, o_head_pc    head entry
//   o_full, o_empty, o_count  occupancy
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned  DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [31:0]   i_push_data,
    input  logic [31:0]   i_push_pc,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [31:0]   o_head_data,
    output logic [31:0]   o_head_pc,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam int unsigned   AW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   r_data [DEPTH];
    logic [31:0]   r_pc   [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    // A full buffer still takes a push when the head leaves in the same cycle.
    assign w_push  = i_push && (!o_full || i_pop);
    assign w_pop   = i_pop && !o_empty;

    assign o_head_data = r_data[r_rptr];
    assign o_head_pc   = r_pc[r_rptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_data[i] <= '0;
                r_pc[i]   <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_data[r_wptr] <= i_push_data;
                r_pc[r_wptr]   <= i_push_pc;
                r_wptr         <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/fetch.sv
// fetch: sequential instruction fetch with redirect, buffering and stale-response discard.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (misaligned-redirect ERR state, o_misaligned).
// Ports:
//   i_clk, i_rst_n                    clock, async active-low reset
//   i_redirect, i_redirect_pc         flush and restart fetch at a new PC
//   o_imem_req_valid/i_imem_req_ready request handshake, o_imem_addr = fetch PC
//   i_imem_rsp_valid, i_imem_rsp_data in-order responses, no backpressure
//   o_inst_valid/i_inst_ready         decode handshake; o_inst, o_inst_pc = buffer head
//   o_misaligned                      set while in ERR (macro builds only)
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        o_misaligned
`endif
);

    localparam int unsigned   CW      = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    logic [FETCH_STATE_WIDTH-1:0] r_state, w_state_d;
    logic [31:0]   r_pc, w_pc_d;
    logic [31:0]   r_rsp_pc, w_rsp_pc_d;    // PC belonging to the next kept response
    logic [CW-1:0] r_outst, w_outst_d;      // live requests awaiting a response
    logic [CW-1:0] r_discard, w_discard_d;  // stale requests whose responses get dropped

    logic [31:0]   w_redirect_pc;
    logic [31:0]   w_head_data;
    logic [31:0]   w_head_pc;
    logic [CW-1:0] w_fifo_count;
    logic [CW-1:0] w_occ;
    logic [CW-1:0] w_inflight;
    logic          w_fifo_full, w_fifo_empty;
    logic          w_pop, w_push, w_rsp_keep;
    logic          w_req_valid, w_req_fire;
    logic          w_rsp_drop, w_rsp_any;

`ifdef FETCH_MISALIGN_CHK_EN
    logic w_redirect_bad;
    assign w_redirect_pc  = i_redirect_pc;
    assign w_redirect_bad = (i_redirect_pc[1:0] != 2'b00);
    assign o_misaligned   = (r_state == ST_ERR);
`else
    assign w_redirect_pc  = pc_align(i_redirect_pc);
`endif

    assign w_pop      = !w_fifo_empty && i_inst_ready && !i_redirect;
    // Credit the pop of this cycle so a steady stream sustains one fetch per cycle.
    assign w_occ      = r_outst + w_fifo_count - CW'(w_pop);
    assign w_rsp_drop = i_imem_rsp_valid && (r_discard != '0);
    // Bounding live + stale requests keeps the discard counter within BUF_DEPTH.
    assign w_inflight = r_outst + r_discard - CW'(w_rsp_drop);
    assign w_req_valid = (r_state == ST_RUN) && (w_occ < DEPTH_C) && (w_inflight < DEPTH_C);
    assign w_req_fire  = w_req_valid && i_imem_req_ready;
    assign w_rsp_any   = i_imem_rsp_valid && ((r_outst != '0) || (r_discard != '0));
    assign w_rsp_keep  = i_imem_rsp_valid && !i_redirect && (r_discard == '0) && (r_outst != '0);
    assign w_push      = w_rsp_keep && (!w_fifo_full || w_pop);

    always_comb begin
        w_state_d   = r_state;
        w_pc_d      = r_pc;
        w_rsp_pc_d  = r_rsp_pc;
        w_outst_d   = r_outst;
        w_discard_d = r_discard;
        if (i_redirect) begin
            // Everything issued so far, including a request accepted now, is stale.
            w_discard_d = r_outst + r_discard + CW'(w_req_fire) - CW'(w_rsp_any);
            w_outst_d   = '0;
            w_pc_d      = w_redirect_pc;
            w_rsp_pc_d  = w_redirect_pc;
            w_state_d   = ST_RUN;
`ifdef FETCH_MISALIGN_CHK_EN
            if (w_redirect_bad) begin
                w_state_d = ST_ERR;
            end
`endif
        end else begin
            if (r_state == ST_BOOT) begin
                w_state_d = ST_RUN;
            end
            if (w_req_fire) begin
                w_pc_d = r_pc + 32'd4;
            end
            if (w_rsp_drop) begin
                w_discard_d = r_discard - 1'b1;
            end
            w_outst_d = r_outst + CW'(w_req_fire) - CW'(w_rsp_keep);
            if (w_rsp_keep) begin
                w_rsp_pc_d = r_rsp_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_BOOT;
            r_pc      <= RESET_PC;
            r_rsp_pc  <= RESET_PC;
            r_outst   <= '0;
            r_discard <= '0;
        end else begin
            r_state   <= w_state_d;
            r_pc      <= w_pc_d;
            r_rsp_pc  <= w_rsp_pc_d;
            r_outst   <= w_outst_d;
            r_discard <= w_discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push),
        .i_push_data (i_imem_rsp_data),
        .i_push_pc   (r_rsp_pc),
        .i_pop       (w_pop),
        .i_flush     (i_redirect),
        .o_head_data (w_head_data),
        .o_head_pc   (w_head_pc),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign o_imem_req_valid = w_req_valid;
    assign o_imem_addr      = r_pc;
    assign o_inst_valid     = !w_fifo_empty;
    assign o_inst           = w_fifo_empty ? '0 : w_head_data;
    assign o_inst_pc        = w_fifo_empty ? '0 : w_head_pc;

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: randomized scoreboard bench for fetch with an in-order memory model.
module tb_fetch;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned BUF_DEPTH = 2;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready = 1'b0;
    logic [31:0] o_imem_addr;
    logic        i_imem_rsp_valid = 1'b0;
    logic [31:0] i_imem_rsp_data = '0;
    logic        o_inst_valid;
    logic        i_inst_ready = 1'b0;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        o_misaligned;
`endif

    fetch #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_redirect       (i_redirect),
        .i_redirect_pc    (i_redirect_pc),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_addr      (o_imem_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .o_inst_valid     (o_inst_valid),
        .i_inst_ready     (i_inst_ready),
        .o_inst           (o_inst),
        .o_inst_pc        (o_inst_pc)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .o_misaligned     (o_misaligned)
`endif
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];     // requests accepted by the memory, oldest first
    logic [31:0] exp_q[$];     // instruction PCs decode must see, in order
    logic [31:0] exp_tail = '0;
    bit          stream_on = 1'b0;

    int checks = 0;
    int passes = 0;
    int consumed = 0;
    int lat_min = 1, lat_max = 1, p_mready = 100, p_iready = 100;

    logic [31:0] req_exp = RESET_PC;
    logic [31:0] last_acc = '0;
    bit          have_last = 1'b0;
    bit          saw_wrap = 1'b0;
    bit          prev_pending = 1'b0;
    logic [31:0] prev_addr = '0;
    bit          mis_exp = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
    endfunction

    // Address the fetch unit is expected to restart from after a redirect.
    function automatic logic [31:0] target(input logic [31:0] pc);
`ifdef FETCH_MISALIGN_CHK_EN
        return pc;
`else
        return pc & 32'hFFFF_FFFC;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic topup();
        while (stream_on && exp_q.size() < 16) begin
            exp_q.push_back(exp_tail);
            exp_tail = exp_tail + 32'd4;
        end
    endtask

    task automatic start_stream(input logic [31:0] pc);
        exp_q.delete();
        exp_tail  = pc;
        stream_on = 1'b1;
        topup();
    endtask

    // One cycle of stimulus: random handshakes, memory response, optional redirect.
    task automatic step(input bit redir, input logic [31:0] rpc);
        @(negedge i_clk);
        #1;
        i_imem_req_ready = (int'($urandom_range(99)) < p_mready);
        i_inst_ready     = (int'($urandom_range(99)) < p_iready);
        i_redirect       = redir;
        i_redirect_pc    = rpc;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            i_imem_rsp_valid = 1'b1;
            i_imem_rsp_data  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            i_imem_rsp_valid = 1'b0;
            i_imem_rsp_data  = $urandom;
        end
        if (redir) begin
`ifdef FETCH_MISALIGN_CHK_EN
            if (rpc[1:0] != 2'b00) begin
                stream_on = 1'b0;
                exp_q.delete();
            end else begin
                start_stream(rpc);
            end
`else
            start_stream(target(rpc));
`endif
        end
        topup();
    endtask

    task automatic apply_reset();
        @(negedge i_clk);
        #1;
        i_rst_n          = 1'b0;
        i_redirect       = 1'b0;
        i_imem_rsp_valid = 1'b0;
        i_imem_req_ready = 1'b0;
        i_inst_ready     = 1'b0;
        mem_q.delete();
        #1;
        check("rst_req_valid", 32'(o_imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(o_inst_valid), 32'd0);
        check("rst_inst", o_inst, 32'd0);
        check("rst_inst_pc", o_inst_pc, 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
        check("rst_misaligned", 32'(o_misaligned), 32'd0);
`endif
        req_exp      = RESET_PC;
        mis_exp      = 1'b0;
        have_last    = 1'b0;
        prev_pending = 1'b0;
        start_stream(RESET_PC);
        repeat (2) @(negedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    // Monitor: samples after the stimulus settles, before the next rising edge.
    initial begin
        int due;
        logic [31:0] e;
        forever begin
            @(negedge i_clk);
            #3;
            if (!i_rst_n) begin
                prev_pending = 1'b0;
                continue;
            end
`ifdef FETCH_MISALIGN_CHK_EN
            check("misaligned", 32'(o_misaligned), 32'(mis_exp));
            if (mis_exp) begin
                check("err_no_req", 32'(o_imem_req_valid), 32'd0);
                check("err_no_inst", 32'(o_inst_valid), 32'd0);
            end
`endif
            if (prev_pending) begin
                check("req_hold_valid", 32'(o_imem_req_valid), 32'd1);
                check("req_hold_addr", o_imem_addr, prev_addr);
            end
            if (o_imem_req_valid && i_imem_req_ready) begin
                check("req_addr", o_imem_addr, req_exp);
                if (have_last && last_acc == 32'hFFFF_FFFC && o_imem_addr == 32'd0) saw_wrap = 1'b1;
                last_acc  = o_imem_addr;
                have_last = 1'b1;
                due = cyc + int'($urandom_range(lat_max, lat_min));
                if (mem_q.size() > 0 && due < mem_q[$].due) due = mem_q[$].due;
                mem_q.push_back('{addr: o_imem_addr, due: due});
                req_exp = req_exp + 32'd4;
            end
            if (i_redirect) begin
                req_exp   = target(i_redirect_pc);
                have_last = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
                mis_exp = (i_redirect_pc[1:0] != 2'b00);
`endif
            end
            check("inflight_bound", 32'(mem_q.size() <= int'(BUF_DEPTH)), 32'd1);
            if (o_inst_valid && i_inst_ready && !i_redirect) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL inst_unexpected: got pc %h want no instruction (cycle %0d)",
                             o_inst_pc, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("inst_pc", o_inst_pc, e);
                    check("inst_data", o_inst, mem_word(e));
                    consumed++;
                end
            end
            prev_pending = o_imem_req_valid && !i_imem_req_ready && !i_redirect;
            prev_addr    = o_imem_addr;
        end
    end

    initial begin
        int c0;
        bit r;
        logic [31:0] rpc;

        apply_reset();

        // Straight-line stream, memory always ready, single-cycle latency.
        lat_min = 1; lat_max = 1; p_mready = 100; p_iready = 100;
        c0 = consumed;
        repeat (20) step(1'b0, '0);
        check("stream_rate", 32'(consumed - c0 >= 14), 32'd1);

        // Decode stalls; buffer and outstanding requests must stay bounded.
        lat_min = 1; lat_max = 3; p_iready = 0;
        repeat (10) step(1'b0, '0);
        p_iready = 100;
        c0 = consumed;
        repeat (12) step(1'b0, '0);
        check("stall_release", 32'(consumed - c0 >= 4), 32'd1);

        // Redirect with responses in flight.
        lat_min = 3; lat_max = 3;
        repeat (8) step(1'b0, '0);
        step(1'b1, 32'h0000_0100);
        c0 = consumed;
        repeat (15) step(1'b0, '0);
        check("redirect_progress", 32'(consumed - c0 >= 5), 32'd1);

        // Fetch PC wraps to zero.
        lat_min = 1; lat_max = 2;
        saw_wrap = 1'b0;
        step(1'b1, 32'hFFFF_FFF8);
        repeat (12) step(1'b0, '0);
        check("pc_wrap", 32'(saw_wrap), 32'd1);

`ifdef FETCH_MISALIGN_CHK_EN
        step(1'b1, 32'h0000_0102);
        repeat (10) step(1'b0, '0);
        check("err_flag_set", 32'(o_misaligned), 32'd1);
        step(1'b1, 32'h0000_0200);
        c0 = consumed;
        repeat (12) step(1'b0, '0);
        check("err_recover", 32'(consumed - c0 >= 4), 32'd1);
`else
        step(1'b1, 32'h0000_0103);
        c0 = consumed;
        repeat (12) step(1'b0, '0);
        check("unaligned_forced", 32'(consumed - c0 >= 4), 32'd1);
`endif

        // Random traffic with a reset in the middle.
        lat_min = 1; lat_max = 4; p_mready = 70; p_iready = 60;
        for (int i = 0; i < 1500; i++) begin
            if (i == 800) apply_reset();
            r   = (int'($urandom_range(99)) < 3);
            rpc = $urandom;
`ifdef FETCH_MISALIGN_CHK_EN
            rpc = rpc & 32'hFFFF_FFFC;
`endif
            step(r, rpc);
        end

        // Drain: everything keeps flowing with no redirects.
        p_mready = 100; p_iready = 100;
        c0 = consumed;
        repeat (40) step(1'b0, '0);
        check("drain_progress", 32'(consumed - c0 >= 20), 32'd1);

        @(negedge i_clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
